sa_pin_host: RTL and testbench
==============================

Name: sa_pin_host

Overview:
- Host-side sequencer that drives the systolic-array tile over its 8-bit TinyTapeout pin interface and collects the product.
- Serialises an N×N matrix pair A,B onto the ui_in/uio_in bus, issues a start strobe, then captures the 16-bit result matrix C from uo_out under the array's result-valid flag.
- Sits opposite the array: drives exactly what the array's inputs consume, and consumes what the array's outputs produce. Used in FPGA bring-up and in loopback simulation.

Parameters:
- N, 2, matrix dimension; element count E = N*N.
- TIMEOUT, 255, max idle cycles waiting for any result byte. Range 1..65535; 16-bit timer.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin one transaction; sampled only in IDLE
- a_flat  input  8*E  matrix A, row-major, element 0 in bits [7:0], unsigned
- b_flat  input  8*E  matrix B, same layout
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction end
- timeout  output  1  high with done when the transaction aborted; holds until next start
- c_flat  output  16*E  captured C, row-major, element 0 in bits [15:0]
- drv_ui  output  8  to array ui_in (data byte)
- drv_uio  output  8  to array uio_in; bit0 = load strobe, bit1 = compute kick, others 0
- sa_uo  input  8  from array uo_out (result byte)
- sa_uio_out  input  8  from array uio_out; bit7 = result byte valid
- sa_uio_oe  input  8  from array uio_oe; bit7 qualifies bit7 of sa_uio_out

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, timeout, drv_ui, drv_uio, c_flat, byte index and timer all 0.
- All outputs are registered. Data valid is rv = sa_uio_out[7] & sa_uio_oe[7].
- IDLE: drv_ui=0, drv_uio=0. On start=1, latch a_flat/b_flat, clear c_flat and timeout, set busy, go LOAD. The first LOAD byte appears on the cycle after start.
- LOAD: runs 2E cycles, index k = 0..2E-1.
  - drv_ui = byte k, where bytes 0..E-1 are A and bytes E..2E-1 are B.
  - drv_uio = 8'h01 each cycle.
  - After k = 2E-1, go KICK.
- KICK: exactly one cycle, drv_ui=0, drv_uio=8'h02. Then go WAIT with timer=0 and byte index j=0.
- WAIT/READ (one combined capture state):
  - Each cycle with rv=1: c_flat byte j <= sa_uo, with bytes LSB-first per element and elements row-major (j=0 → C0[7:0], j=1 → C0[15:8], ...). Then j++ and timer cleared.
  - Each cycle with rv=0: timer++.
  - Gaps between bytes are legal.
  - When j reaches 2E, go DONE. rv in later cycles is ignored.
  - If timer reaches TIMEOUT with rv=0, set timeout=1 and go DONE. Bytes captured so far are kept; uncaptured bytes stay 0.
  - If rv=1 on the same cycle the timer would expire, the capture wins and the timer clears.
  - drv_ui=0 and drv_uio=0 throughout.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
  - start is ignored in DONE and in every busy state; no queuing.
  - start may be accepted on the cycle after DONE.
- Latency (N=2): start sampled at cycle 0; LOAD occupies cycles 1–8; KICK at 9; capture from 10. With back-to-back rv, done is at cycle 18.
- Reset mid-transaction aborts immediately with no done pulse. drv_uio drops to 0 asynchronously.
- c_flat holds its value from DONE until the next accepted start.

Test Plan:
- Identity: A=I (1,0,0,1), B=(2,3,4,5); responder model returns C bytes 02 00 03 00 04 00 05 00 back-to-back, rv from cycle 10 → drv_ui sequence 01 00 00 01 02 03 04 05 with drv_uio=01, then one 02 cycle; c_flat={0005,0004,0003,0002}; done at cycle 18, timeout=0.
- Gapped results: A=B=all 8'hFF; model returns 16'hFE01 ×4 with rv low for 3 cycles between each byte → c_flat all FE01, done asserted, no timeout.
- Timeout: TIMEOUT=20; model returns only 3 bytes then holds rv=0 → timeout=1 with done exactly 20 idle cycles after the 3rd byte; C0=captured value, C1 high byte and C2–C3 = 0.
- OE masking: sa_uio_out[7]=1 but sa_uio_oe[7]=0 for 10 cycles → no capture and timer counts; raising oe then captures normally.
- start held high throughout → exactly one transaction per IDLE entry; start high in the DONE cycle is not accepted; start one cycle later is accepted.
- Reset mid-LOAD (rst_n low at cycle 4, async) → drv_uio=0 and busy=0 immediately, no done pulse; a subsequent start completes a full, correct transaction.

Source files
------------

// File: rtl/sa_pin_host_if.sv
// Pin-level bus between the host sequencer and the systolic-array tile.
// master = host side (drives ui/uio), slave = array side (drives uo/uio_out/uio_oe).
interface sa_pin_host_if;
    logic [7:0] drv_ui;
    logic [7:0] drv_uio;
    logic [7:0] sa_uo;
    logic [7:0] sa_uio_out;
    logic [7:0] sa_uio_oe;

    modport master (output drv_ui, drv_uio, input sa_uo, sa_uio_out, sa_uio_oe);
    modport slave  (input drv_ui, drv_uio, output sa_uo, sa_uio_out, sa_uio_oe);
endinterface

// File: rtl/sa_pin_host.sv
// Host sequencer: streams A then B into the array, kicks it, then gathers the
// 16-bit result matrix byte by byte with an idle-cycle timeout.
module sa_pin_host #(
    parameter int N       = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*N*N-1:0]    a_flat,
    input  logic [8*N*N-1:0]    b_flat,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [16*N*N-1:0]   c_flat,
    sa_pin_host_if.master       pins
);
    localparam int E     = N * N;
    localparam int BYTES = 2 * E;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DONE} state_t;

    state_t                 state_q;
    logic [BYTES-1:0][7:0]  ab_q;
    logic [BYTES-1:0][7:0]  c_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_d;
    logic [15:0]            timer_q;
    logic                   busy_q, done_q, timeout_q;
    logic [7:0]             ui_q, uio_q;

    logic rv, last_idx, tmo_hit;
    logic unused_bits;

    // Bit7 of uio_out only counts when the array actually drives it.
    assign rv       = pins.sa_uio_out[7] & pins.sa_uio_oe[7];
    assign idx_d    = idx_q + IW'(1);
    assign last_idx = (idx_q == IW'(BYTES - 1));
    assign tmo_hit  = (({1'b0, timer_q} + 17'd1) == 17'(TIMEOUT));
    assign unused_bits = ^{pins.sa_uio_out[6:0], pins.sa_uio_oe[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ab_q      <= '0;
            c_q       <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            ui_q      <= '0;
            uio_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    ab_q      <= {b_flat, a_flat};
                    c_q       <= '0;
                    timeout_q <= 1'b0;
                    busy_q    <= 1'b1;
                    idx_q     <= '0;
                    ui_q      <= a_flat[7:0];
                    uio_q     <= 8'h01;
                    state_q   <= S_LOAD;
                end
                S_LOAD: if (last_idx) begin
                    ui_q    <= '0;
                    uio_q   <= 8'h02;
                    state_q <= S_KICK;
                end else begin
                    idx_q <= idx_d;
                    ui_q  <= ab_q[idx_d];
                end
                S_KICK: begin
                    uio_q   <= '0;
                    idx_q   <= '0;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: if (rv) begin
                    // A byte arriving on the expiry cycle still counts.
                    c_q[idx_q] <= pins.sa_uo;
                    idx_q      <= idx_d;
                    timer_q    <= '0;
                    if (last_idx) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end else if (tmo_hit) begin
                    timeout_q <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= S_DONE;
                end else begin
                    timer_q <= timer_q + 16'd1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign c_flat       = c_q;
    assign pins.drv_ui  = ui_q;
    assign pins.drv_uio = uio_q;
endmodule

// File: tb/tb_sa_pin_host.sv
// Bench for sa_pin_host: a cycle-level transaction model plus an array responder,
// with a single compare process checking every DUT output each cycle.
module tb_sa_pin_host;
    localparam int N = 2, E = 4, NB = 8, TMO = 20, CW = 16 * E;

    logic clk = 1'b0;
    logic rst_n, start;
    logic [8*E-1:0] a_flat, b_flat;
    logic busy, done, timeout;
    logic [CW-1:0] c_flat;

    sa_pin_host_if pins();

    sa_pin_host #(.N(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_flat(a_flat), .b_flat(b_flat),
        .busy(busy), .done(done), .timeout(timeout), .c_flat(c_flat), .pins(pins)
    );

    always #5 clk = ~clk;

    // expectations for the current cycle
    logic [7:0] e_ui, e_uio;
    logic e_busy, e_done, e_to;
    logic [CW-1:0] e_c;
    bit chk_en = 1'b0;
    int n_chk = 0, n_err = 0;
    event kick_ev;
    int lit_req = 0, lit_seen = 0;
    string lit_name;
    logic [CW-1:0] lit_act, lit_exp;

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always begin
        @(negedge clk or kick_ev);
        if (lit_req != lit_seen) begin
            lit_seen = lit_req;
            check(lit_name, lit_act, lit_exp);
        end else if (chk_en) begin
            check("drv_ui",  CW'(pins.drv_ui),  CW'(e_ui));
            check("drv_uio", CW'(pins.drv_uio), CW'(e_uio));
            check("busy",    CW'(busy),    CW'(e_busy));
            check("done",    CW'(done),    CW'(e_done));
            check("timeout", CW'(timeout), CW'(e_to));
            check("c_flat",  c_flat, e_c);
        end
    end

    // model / stimulus state
    logic [7:0] ab_m [NB];
    logic [7:0] resp [NB];
    int nsend, gap_cfg, mask_n;
    logic [CW-1:0] prev_c;
    logic prev_to;
    int done_cyc, third_cyc;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic lit(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        lit_name = nm; lit_act = act; lit_exp = exp;
        lit_req++;
        ->kick_ev;
        #0;
    endtask

    task automatic set_exp(input logic [7:0] ui, input logic [7:0] uio, input logic b,
                           input logic d, input logic t, input logic [CW-1:0] c);
        e_ui = ui; e_uio = uio; e_busy = b; e_done = d; e_to = t; e_c = c;
    endtask

    // bus activity the host must ignore outside its capture window
    task automatic noise();
        pins.sa_uo      = 8'($urandom);
        pins.sa_uio_out = 8'($urandom);
        pins.sa_uio_oe  = 8'($urandom);
    endtask

    function automatic logic [CW-1:0] pack(input logic [7:0] m [NB]);
        logic [CW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*8 +: 8] = m[i];
        return r;
    endfunction

    task automatic mk_product();
        logic [15:0] s;
        for (int i = 0; i < N; i++)
            for (int c = 0; c < N; c++) begin
                s = 16'd0;
                for (int k = 0; k < N; k++) s += 16'(ab_m[i*N+k]) * 16'(ab_m[E+k*N+c]);
                resp[2*(i*N+c)]   = s[7:0];
                resp[2*(i*N+c)+1] = s[15:8];
            end
    endtask

    task automatic idle_step();
        step(); start = 1'b0; noise();
        set_exp(8'h00, 8'h00, 1'b0, 1'b0, prev_to, prev_c);
    endtask

    // One full transaction: idle cycle with start, LOAD, KICK, capture, DONE.
    task automatic run_txn(input bit hold);
        logic [7:0] mc [NB];
        logic [7:0] uo, uout, uoe;
        int j, idle, sent, wait_c, mask_left, cyc;
        bit rvb, to;
        step(); cyc = 0;
        for (int i = 0; i < E; i++) begin
            a_flat[i*8 +: 8] = ab_m[i];
            b_flat[i*8 +: 8] = ab_m[E+i];
        end
        start = 1'b1; noise();
        set_exp(8'h00, 8'h00, 1'b0, 1'b0, prev_to, prev_c);
        for (int k = 0; k < NB; k++) begin
            step(); cyc++; start = hold; noise();
            a_flat = {$urandom, $urandom}; b_flat = {$urandom, $urandom};
            set_exp(ab_m[k], 8'h01, 1'b1, 1'b0, 1'b0, '0);
        end
        step(); cyc++; start = hold; noise();
        set_exp(8'h00, 8'h02, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < NB; i++) mc[i] = 8'h00;
        j = 0; idle = 0; sent = 0; wait_c = 0; mask_left = mask_n; to = 1'b0;
        for (int guard = 0; guard < 1000; guard++) begin
            step(); cyc++; start = hold;
            set_exp(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, pack(mc));
            if (mask_left > 0) begin
                uo = 8'($urandom); uout = 8'($urandom) | 8'h80; uoe = 8'($urandom) & 8'h7f;
                mask_left--; rvb = 1'b0;
            end else if (sent < nsend && wait_c == 0) begin
                uo = resp[sent]; uout = 8'($urandom) | 8'h80; uoe = 8'($urandom) | 8'h80;
                sent++; rvb = 1'b1;
                wait_c = (gap_cfg < 0) ? int'($urandom_range(0, 4)) : gap_cfg;
            end else begin
                uo = 8'($urandom); uout = 8'($urandom); uoe = 8'($urandom);
                if (uout[7]) uoe[7] = 1'b0;
                rvb = 1'b0;
                if (wait_c > 0) wait_c--;
            end
            pins.sa_uo = uo; pins.sa_uio_out = uout; pins.sa_uio_oe = uoe;
            if (rvb) begin
                mc[j] = uo; j++; idle = 0;
                if (j == 3) third_cyc = cyc;
            end else idle++;
            if (j == NB) break;
            if (idle == TMO) begin to = 1'b1; break; end
        end
        step(); cyc++; start = hold; noise();
        set_exp(8'h00, 8'h00, 1'b0, 1'b1, to, pack(mc));
        done_cyc = cyc; prev_c = pack(mc); prev_to = to;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; a_flat = '0; b_flat = '0;
        pins.sa_uo = '0; pins.sa_uio_out = '0; pins.sa_uio_oe = '0;
        prev_c = '0; prev_to = 1'b0; done_cyc = 0; third_cyc = 0;
        nsend = NB; gap_cfg = 0; mask_n = 0;
        #2 rst_n = 1'b0;
        step(); step();
        set_exp(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        chk_en = 1'b1;
        step(); rst_n = 1'b1;
        idle_step();

        // identity A, B = 2..5
        ab_m = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        resp = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
        nsend = NB; gap_cfg = 0; mask_n = 0;
        run_txn(1'b0);
        lit("identity_c", prev_c, 64'h0005_0004_0003_0002);
        lit("identity_done_cycle", CW'(done_cyc), CW'(18));
        idle_step();

        // all-FF operands, results with 3-cycle gaps
        for (int i = 0; i < NB; i++) ab_m[i] = 8'hFF;
        for (int i = 0; i < NB; i++) resp[i] = (i % 2 == 0) ? 8'h01 : 8'hFE;
        gap_cfg = 3;
        run_txn(1'b0);
        lit("gapped_c", prev_c, {4{16'hFE01}});
        lit("gapped_no_timeout", CW'(prev_to), CW'(0));
        idle_step();

        // only three result bytes, then silence
        resp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        gap_cfg = 0; nsend = 3;
        run_txn(1'b0);
        lit("timeout_flag", CW'(prev_to), CW'(1));
        lit("timeout_c", prev_c, 64'h0000_0000_0033_2211);
        lit("timeout_idle_gap", CW'(done_cyc - third_cyc - 1), CW'(TMO));
        lit("timeout_done_cycle", CW'(done_cyc), CW'(33));
        idle_step(); idle_step();

        // uio_out[7] high but not output-enabled for 10 cycles
        for (int i = 0; i < NB; i++) ab_m[i] = 8'($urandom);
        mk_product(); nsend = NB; mask_n = 10;
        run_txn(1'b0);
        mask_n = 0;
        idle_step();

        // start held high: back-to-back transactions, DONE-cycle start ignored
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NB; i++) ab_m[i] = 8'($urandom);
            mk_product(); gap_cfg = -1;
            run_txn(1'b1);
        end
        idle_step();

        // reset in the middle of LOAD, then a clean identity run
        ab_m = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < E; i++) begin
            a_flat[i*8 +: 8] = ab_m[i];
            b_flat[i*8 +: 8] = ab_m[E+i];
        end
        step(); start = 1'b1;
        set_exp(8'h00, 8'h00, 1'b0, 1'b0, prev_to, prev_c);
        for (int k = 0; k < 4; k++) begin
            step(); start = 1'b0;
            set_exp(ab_m[k], 8'h01, 1'b1, 1'b0, 1'b0, '0);
        end
        #2 rst_n = 1'b0; start = 1'b1;
        #1 set_exp(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, '0);
        ->kick_ev;
        step(); step(); start = 1'b0;
        rst_n = 1'b1; prev_c = '0; prev_to = 1'b0;
        resp = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
        nsend = NB; gap_cfg = 0;
        run_txn(1'b0);
        lit("post_reset_c", prev_c, 64'h0005_0004_0003_0002);
        idle_step();

        // randomized operands, gaps, early silence and start holding
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NB; i++) ab_m[i] = 8'($urandom);
            mk_product();
            gap_cfg = -1;
            nsend = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB - 1)) : NB;
            run_txn(1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_step();
        end
        idle_step();
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
